// File: rtl/maze_mem_sequencer_if.sv
// maze_mem_sequencer_if: maze cell RAM port (addr, wdata, we, re driven by master; rdata driven by slave)
interface maze_mem_sequencer_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic mem_we;
  logic mem_re;
  modport master(output mem_addr, mem_wdata, mem_we, mem_re, input mem_rdata);
  modport slave(input mem_addr, mem_wdata, mem_we, mem_re, output mem_rdata);
endinterface

// File: rtl/maze_mem_sequencer.sv
// maze_mem_sequencer: fills maze RAM then runs bounds/wall-checked player moves; ports clk, nst, start, key_valid/key_value in, mem RAM bus, pos/busy/done/bump out
module maze_mem_sequencer #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 6,
  parameter int DEPTH = 64,
  parameter int COLS = 8,
  parameter int FILL_MOD = 4,
  parameter int WALL_CODE = 15,
  parameter int EMPTY_CODE = 0,
  parameter int PLAYER_CODE = 14
) (
  input  logic clk,
  input  logic nst,
  input  logic start,
  input  logic key_valid,
  input  logic [3:0] key_value,
  maze_mem_sequencer_if.master mem,
  output logic [ADDR_W-1:0] pos,
  output logic busy,
  output logic done,
  output logic bump
);
  typedef enum logic [3:0] {
    IDLE, FILL_WR, FILL_GAP, PLR_WR, PLR_GAP, DONE, READY,
    RD, CHK, WR_OLD, GAP, WR_NEW, BUMP
  } state_t;
  state_t state, next;
  logic [ADDR_W-1:0] cnt, tgt;
  logic [ADDR_W:0] cand;
  logic [31:0] col;
  logic oob, key_ok;
  assign col = 32'(pos) % COLS;
  assign key_ok = key_valid && key_value[3:2] == 2'b00;
  always_comb begin
    cand = key_value[1] ? (key_value[0] ? {1'b0, pos} + (ADDR_W+1)'(1) : {1'b0, pos} - (ADDR_W+1)'(1))
                        : (key_value[0] ? {1'b0, pos} + (ADDR_W+1)'(COLS) : {1'b0, pos} - (ADDR_W+1)'(COLS));
    oob = cand[ADDR_W] || 32'(cand) >= DEPTH
          || (key_value == 4'd2 && col == 0) || (key_value == 4'd3 && col == COLS - 1);
  end
  always_ff @(posedge clk or negedge nst) begin
    if (!nst) begin
      state <= IDLE;
      cnt <= '0;
      tgt <= '0;
      pos <= '0;
    end else begin
      state <= next;
      cnt <= state == FILL_GAP ? cnt + ADDR_W'(1) : (state == IDLE || state == READY) ? '0 : cnt;
      tgt <= state == READY ? cand[ADDR_W-1:0] : tgt;
      pos <= state == PLR_GAP ? '0 : state == WR_NEW ? tgt : pos;
    end
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = start ? FILL_WR : IDLE;
      FILL_WR:  next = FILL_GAP;
      FILL_GAP: next = cnt == ADDR_W'(DEPTH - 1) ? PLR_WR : FILL_WR;
      PLR_WR:   next = PLR_GAP;
      PLR_GAP:  next = DONE;
      DONE:     next = READY;
      READY:    next = start ? FILL_WR : key_ok ? (oob ? BUMP : RD) : READY;
      RD:       next = CHK;
      CHK:      next = mem.mem_rdata == DATA_W'(WALL_CODE) ? BUMP : WR_OLD;
      WR_OLD:   next = GAP;
      GAP:      next = WR_NEW;
      WR_NEW:   next = DONE;
      BUMP:     next = READY;
      default:  next = IDLE;
    endcase
  end
  always_comb begin
    busy = !(state == IDLE || state == READY);
    done = state == DONE;
    bump = state == BUMP;
    mem.mem_we = state inside {FILL_WR, PLR_WR, WR_OLD, WR_NEW};
    mem.mem_re = state == RD;
    mem.mem_addr = state == FILL_WR ? cnt : state == WR_OLD ? pos
                 : (state == RD || state == WR_NEW) ? tgt : '0;
    mem.mem_wdata = state == FILL_WR ? DATA_W'(32'(cnt) % FILL_MOD + 1)
                  : (state == PLR_WR || state == WR_NEW) ? DATA_W'(PLAYER_CODE)
                  : state == WR_OLD ? DATA_W'(EMPTY_CODE) : '0;
  end
endmodule

// File: tb/tb_maze_mem_sequencer.sv
// tb_maze_mem_sequencer: randomized self-checking bench with a row/column maze model and a RAM model
module tb_maze_mem_sequencer;
  localparam int DW = 4, AW = 6, DEPTH = 64, COLS = 8, ROWS = DEPTH / COLS;
  typedef logic [20:0] vec_t;
  logic clk = 0, nst = 0, start = 0, key_valid = 0;
  logic [3:0] key_value = 0;
  logic [AW-1:0] pos;
  logic busy, done, bump;
  logic [DW-1:0] ram [DEPTH];
  logic poke = 0;
  logic [AW-1:0] poke_a = 0;
  int n_chk = 0, n_fail = 0, mpos = 0;
  int mmem [DEPTH];
  vec_t obs;
  maze_mem_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
  maze_mem_sequencer dut (
    .clk(clk), .nst(nst), .start(start), .key_valid(key_valid), .key_value(key_value),
    .mem(bus.master), .pos(pos), .busy(busy), .done(done), .bump(bump)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (poke) ram[poke_a] <= 4'd15;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
  end
  assign obs = {busy, done, bump, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata, pos};
  function automatic vec_t v(input bit b, d, u, w, r, input int a, wd, p);
    return {b, d, u, w, r, 6'(a), 4'(wd), 6'(p)};
  endfunction
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_held: got %h want %h", obs, vec_t'(0)); end
    nst = 1;
    @(negedge clk);
    n_chk++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_release: got %h want %h", obs, vec_t'(0)); end
  endtask
  task automatic test_fill(input bit with_key);
    vec_t e, m;
    int k;
    @(negedge clk);
    start = 1;
    key_valid = with_key;
    key_value = 3;
    for (int i = 1; i <= 132; i++) begin
      @(negedge clk);
      k = (i - 1) / 2;
      e = (i <= 127 && i % 2 == 1) ? v(1, 0, 0, 1, 0, k, k % 4 + 1, 0)
        : i == 129 ? v(1, 0, 0, 1, 0, 0, 14, 0)
        : i == 131 ? v(1, 1, 0, 0, 0, 0, 0, 0)
        : i == 132 ? v(0, 0, 0, 0, 0, 0, 0, 0) : v(1, 0, 0, 0, 0, 0, 0, 0);
      m = i >= 131 ? '1 : {15'h7fff, 6'h0};
      n_chk++;
      if ((obs & m) !== (e & m)) begin
        n_fail++;
        $display("FAIL fill cycle %0d (key=%0d): got %h want %h", i, with_key, obs & m, e & m);
      end
      start = i <= 131 ? 1'($urandom % 2) : 1'b0;
      key_valid = i <= 131 ? 1'($urandom % 2) : 1'b0;
      key_value = 4'($urandom % 16);
    end
    for (int a = 0; a < DEPTH; a++) mmem[a] = a % 4 + 1;
    mmem[0] = 14;
    mpos = 0;
  endtask
  task automatic move(input logic [3:0] key, input string tag);
    vec_t q[$];
    int r = mpos / COLS, c = mpos % COLS, t = 0;
    bit ok = 0;
    case (key)
      4'd0: begin ok = r > 0; t = mpos - COLS; end
      4'd1: begin ok = r < ROWS - 1; t = mpos + COLS; end
      4'd2: begin ok = c > 0; t = mpos - 1; end
      4'd3: begin ok = c < COLS - 1; t = mpos + 1; end
      default: ok = 0;
    endcase
    if (key > 3) repeat (3) q.push_back(v(0, 0, 0, 0, 0, 0, 0, mpos));
    else if (!ok) begin
      q.push_back(v(1, 0, 1, 0, 0, 0, 0, mpos));
      q.push_back(v(0, 0, 0, 0, 0, 0, 0, mpos));
    end else if (mmem[t] == 15) begin
      q.push_back(v(1, 0, 0, 0, 1, t, 0, mpos));
      q.push_back(v(1, 0, 0, 0, 0, 0, 0, mpos));
      q.push_back(v(1, 0, 1, 0, 0, 0, 0, mpos));
      q.push_back(v(0, 0, 0, 0, 0, 0, 0, mpos));
    end else begin
      q.push_back(v(1, 0, 0, 0, 1, t, 0, mpos));
      q.push_back(v(1, 0, 0, 0, 0, 0, 0, mpos));
      q.push_back(v(1, 0, 0, 1, 0, mpos, 0, mpos));
      q.push_back(v(1, 0, 0, 0, 0, 0, 0, mpos));
      q.push_back(v(1, 0, 0, 1, 0, t, 14, mpos));
      q.push_back(v(1, 1, 0, 0, 0, 0, 0, t));
      q.push_back(v(0, 0, 0, 0, 0, 0, 0, t));
      mmem[mpos] = 0;
      mmem[t] = 14;
      mpos = t;
    end
    @(negedge clk);
    key_valid = 1;
    key_value = key;
    foreach (q[i]) begin
      @(negedge clk);
      key_valid = 0;
      n_chk++;
      if (obs !== q[i]) begin
        n_fail++;
        $display("FAIL %s key=%0d cycle %0d: got %h want %h", tag, key, i + 1, obs, q[i]);
      end
    end
  endtask
  task automatic set_wall(input int a);
    @(negedge clk);
    poke = 1;
    poke_a = 6'(a);
    @(negedge clk);
    poke = 0;
    mmem[a] = 15;
  endtask
  task automatic test_edge_bumps();
    move(4'd0, "bump_up_at_0");
    move(4'd2, "bump_left_at_0");
  endtask
  task automatic test_wall();
    set_wall(8);
    move(4'd1, "wall_down");
  endtask
  task automatic test_moves();
    move(4'd3, "right_0_to_1");
    while (mpos != 7) move(4'd3, "walk_right");
    move(4'd3, "bump_right_at_7");
    repeat (7) move(4'd1, "walk_down");
    move(4'd1, "bump_down_at_bottom");
  endtask
  task automatic test_invalid_key();
    move(4'd9, "key_9_ignored");
    move(4'd4, "key_4_ignored");
  endtask
  task automatic test_random();
    int a;
    for (int n = 0; n < 60; n++) begin
      if ($urandom % 5 == 0) begin
        a = int'($urandom % DEPTH);
        if (a != mpos) set_wall(a);
      end
      move($urandom % 6 == 0 ? 4'(4 + $urandom % 12) : 4'($urandom % 4), "random");
    end
  endtask
  task automatic test_reset_midfill();
    @(negedge clk);
    start = 1;
    repeat (40) begin @(negedge clk); start = 0; end
    #2 nst = 0;
    #1;
    n_chk++;
    if (obs !== '0) begin n_fail++; $display("FAIL async_reset_midfill: got %h want %h", obs, vec_t'(0)); end
    @(negedge clk);
    nst = 1;
    @(negedge clk);
    n_chk++;
    if (obs !== '0) begin n_fail++; $display("FAIL no_resume_after_reset: got %h want %h", obs, vec_t'(0)); end
    mpos = 0;
  endtask
  initial begin
    test_reset();
    test_fill(0);
    test_edge_bumps();
    test_wall();
    test_moves();
    test_invalid_key();
    test_random();
    test_fill(1);
    test_invalid_key();
    test_reset_midfill();
    test_fill(0);
    move(4'd3, "right_after_refill");
    for (int a = 0; a < DEPTH; a++) begin
      n_chk++;
      if (int'(ram[a]) !== mmem[a]) begin
        n_fail++;
        $display("FAIL ram_content addr %0d: got %0d want %0d", a, ram[a], mmem[a]);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
